// File: rtl/btn_event_pkg.sv
// rtl/btn_event_pkg.sv - shared event layout and button count for btn_event_ctrl
package btn_event_pkg;

    localparam int NBTN      = 4;
    localparam int EV_W      = 8;
    localparam int PRESS_BIT = 7;
    localparam int IDX_LSB   = 0;
    localparam int IDX_MSB   = 1;
    localparam int IDX_W     = IDX_MSB - IDX_LSB + 1;

    typedef logic [EV_W-1:0]  ev_t;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic ev_t make_event(input logic press, input idx_t idx);
        ev_t ev;
        ev                  = '0;
        ev[PRESS_BIT]       = press;
        ev[IDX_MSB:IDX_LSB] = idx;
        return ev;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - per-button 2-flop synchronizer and saturating-run debouncer
module btn_debounce #(
    parameter int DBITS = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic level_o,
    output logic change_o
);

    localparam logic [DBITS-1:0] CNT_MAX = '1;

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [DBITS-1:0] cnt_q, cnt_d;
    logic             differ;

    // change_o is combinational so the parent can latch the event on the same edge the level flips
    always_comb begin
        differ   = (sync2_q != level_q);
        change_o = differ && (cnt_q == CNT_MAX);
        level_d  = level_q;
        cnt_d    = '0;
        if (change_o) begin
            level_d = sync2_q;
        end else if (differ) begin
            cnt_d = cnt_q + {{(DBITS-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/btn_event_ctrl.sv
// rtl/btn_event_ctrl.sv - debounced buttons to event FIFO; BTN_EVENT_IRQ_EN enables registered irq
module btn_event_ctrl
    import btn_event_pkg::*;
#(
    parameter int DBITS  = 16,
    parameter int FDEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NBTN-1:0] btn_in,
    output logic [NBTN-1:0] btn_state,
    output logic            ev_valid,
    input  logic            ev_ready,
    output logic [EV_W-1:0] ev_data,
    output logic            ovf,
    input  logic            ovf_clr,
    output logic            irq
);

    localparam int AW = (FDEPTH > 1) ? $clog2(FDEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FDEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [NBTN-1:0] btn_chg, btn_lvl;

    for (genvar gi = 0; gi < NBTN; gi++) begin : g_db
        btn_debounce #(.DBITS(DBITS)) u_db (
            .clk      (clk),
            .rst      (rst),
            .btn_i    (btn_in[gi]),
            .level_o  (btn_lvl[gi]),
            .change_o (btn_chg[gi])
        );
    end

    assign btn_state = btn_lvl;

    logic [NBTN-1:0] pend_q, pend_d, pol_q, pol_d;
    logic [AW-1:0]   wr_q, rd_q;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    ev_t             mem_q [FDEPTH];

    logic            pop, push, full, ovf_hit;
    idx_t            grant_idx;
    ev_t             push_ev;

    always_comb begin
        full      = (cnt_q == FULL_CNT);
        pop       = (cnt_q != '0) && ev_ready;
        push      = (|pend_q) && (!full || pop);
        grant_idx = '0;
        for (int i = NBTN-1; i >= 0; i--) begin
            if (pend_q[i]) grant_idx = idx_t'(i);
        end
        push_ev = make_event(pol_q[grant_idx], grant_idx);

        pend_d  = pend_q;
        pol_d   = pol_q;
        ovf_hit = 1'b0;
        if (push) pend_d[grant_idx] = 1'b0;
        // A change on a button whose previous event is still pending counts as overflow,
        // and the newest level replaces the pending polarity.
        for (int i = 0; i < NBTN; i++) begin
            if (btn_chg[i]) begin
                if (pend_q[i]) ovf_hit = 1'b1;
                pend_d[i] = 1'b1;
                pol_d[i]  = ~btn_lvl[i];
            end
        end

        ovf_d = ovf_q;
        if (ovf_clr)      ovf_d = 1'b0;
        else if (ovf_hit) ovf_d = 1'b1;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q <= '0;
            pol_q  <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            pol_q  <= pol_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            if (push) wr_q <= wr_q + PTR_ONE;
            if (pop)  rd_q <= rd_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_ev;
    end

    assign ev_valid = (cnt_q != '0);
    assign ev_data  = ev_valid ? mem_q[rd_q] : '0;
    assign ovf      = ovf_q;

`ifdef BTN_EVENT_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= 1'b0;
        else     irq_q <= ev_valid | ovf_q;
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_ctrl.sv
// tb/tb_btn_event_ctrl.sv - randomized and directed bench with behavioural event model
module tb_btn_event_ctrl;

    localparam int DBITS  = 2;
    localparam int FDEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, ev_ready, ovf_clr;
    logic [3:0] btn_in, btn_state;
    logic       ev_valid, ovf, irq;
    logic [7:0] ev_data;

    always #5 clk = ~clk;

    btn_event_ctrl #(.DBITS(DBITS), .FDEPTH(FDEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .btn_state (btn_state),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_data   (ev_data),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .irq       (irq)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: inputs reach the debouncer two samples late; a level is accepted
    // on the 2^DBITS-th consecutive differing sample; events queue in arrival order.
    logic [3:0] m_dly[$];
    logic [3:0] m_state, m_pend, m_pol;
    int         m_run[4];
    logic [7:0] m_q[$];
    logic       m_ovf, m_irq;

    task automatic model_reset();
        m_dly.delete();
        m_dly.push_back(4'h0);
        m_dly.push_back(4'h0);
        m_q.delete();
        m_state = '0;
        m_pend  = '0;
        m_pol   = '0;
        m_ovf   = 1'b0;
        m_irq   = 1'b0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] smp, chg, pend_old;
        bit         pop, push, ovf_set;
        int         g;
`ifdef BTN_EVENT_IRQ_EN
        m_irq = (m_q.size() != 0) || m_ovf;
`else
        m_irq = 1'b0;
`endif
        smp = m_dly.pop_front();
        m_dly.push_back(btn_in);
        chg = '0;
        for (int i = 0; i < 4; i++) begin
            if (smp[i] != m_state[i]) begin
                m_run[i]++;
                if (m_run[i] == (1 << DBITS)) begin
                    chg[i]   = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        pop      = (m_q.size() != 0) && ev_ready;
        push     = (m_pend != 0) && ((m_q.size() < FDEPTH) || pop);
        pend_old = m_pend;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            g = 0;
            while (!m_pend[g]) g++;
            m_q.push_back({m_pol[g], 5'b0, 2'(g)});
            m_pend[g] = 1'b0;
        end
        ovf_set = 0;
        for (int i = 0; i < 4; i++) begin
            if (chg[i]) begin
                if (pend_old[i]) ovf_set = 1;
                m_pend[i]  = 1'b1;
                m_state[i] = ~m_state[i];
                m_pol[i]   = m_state[i];
            end
        end
        if (ovf_clr)      m_ovf = 1'b0;
        else if (ovf_set) m_ovf = 1'b1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) model_reset();
        else     model_step();
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            chk("btn_state", btn_state, m_state);
            chk("ev_valid", ev_valid, m_q.size() != 0);
            if (m_q.size() != 0) chk("ev_data", ev_data, m_q[0]);
            chk("ovf", ovf, m_ovf);
            chk("irq", irq, m_irq);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #3;
    endtask

    task automatic wait_valid(input string name);
        for (int k = 0; k < 30; k++) begin
            if (ev_valid) break;
            step(1);
        end
        chk(name, ev_valid, 1'b1);
    endtask

    initial begin
        rst = 1'b1; btn_in = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
        step(2);
        chk("rst_btn_state", btn_state, 4'h0);
        chk("rst_ev_valid", ev_valid, 1'b0);
        chk("rst_ev_data", ev_data, 8'h00);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_irq", irq, 1'b0);
        rst = 1'b0;
        step(2);

        // single press: level accepted on the 6th edge, event visible on the 7th
        btn_in = 4'b0001;
        step(5);
        chk("press_not_yet", btn_state[0], 1'b0);
        step(1);
        chk("press_state", btn_state[0], 1'b1);
        chk("press_no_ev_yet", ev_valid, 1'b0);
        step(1);
        chk("press_ev_valid", ev_valid, 1'b1);
        chk("press_ev_data", ev_data, 8'h80);
        ev_ready = 1'b1;
        step(1);
        chk("press_popped", ev_valid, 1'b0);
        btn_in = 4'b0000;
        step(12);
        chk("release_drained", ev_valid, 1'b0);

        // bounce: three high samples are not enough
        btn_in = 4'b0100;
        step(3);
        btn_in = 4'b0000;
        step(12);
        chk("bounce_state", btn_state, 4'h0);
        chk("bounce_no_ev", ev_valid, 1'b0);

        // simultaneous edges pushed lowest index first, one per cycle
        btn_in = 4'b1111;
        wait_valid("simul_wait");
        chk("simul_ev0", ev_data, 8'h80);
        step(1); chk("simul_ev1", ev_data, 8'h81);
        step(1); chk("simul_ev2", ev_data, 8'h82);
        step(1); chk("simul_ev3", ev_data, 8'h83);
        step(1); chk("simul_empty", ev_valid, 1'b0);
        btn_in = 4'b0000;
        step(15);
        chk("simul_drained", ev_valid, 1'b0);

        // full FIFO, pending button 3 overwritten, overflow flagged
        ev_ready = 1'b0;
        btn_in = 4'b0111; step(10);
        btn_in = 4'b0110; step(10);
        chk("full_head", ev_data, 8'h80);
        btn_in = 4'b1110; step(10);
        chk("full_no_ovf", ovf, 1'b0);
        btn_in = 4'b0110; step(10);
        chk("full_ovf", ovf, 1'b1);
        chk("full_head_held", ev_data, 8'h80);
        ev_ready = 1'b1;
        step(1); chk("full_pop1", ev_data, 8'h81);
        step(1); chk("full_pop2", ev_data, 8'h82);
        step(1); chk("full_pop3", ev_data, 8'h00);
        step(1); chk("full_pop4", ev_data, 8'h03);
        step(1); chk("full_empty", ev_valid, 1'b0);
        ovf_clr = 1'b1; step(1); ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 1'b0);

        // reset mid-operation with two queued events
        ev_ready = 1'b0;
        btn_in = 4'b0000;
        step(10);
        chk("midrst_head", ev_data, 8'h01);
        rst = 1'b1;
        #1;
        chk("midrst_ev_valid", ev_valid, 1'b0);
        chk("midrst_ovf", ovf, 1'b0);
        chk("midrst_irq", irq, 1'b0);
        chk("midrst_state", btn_state, 4'h0);
        step(1);
        rst = 1'b0;
        step(3);
        chk("midrst_after", ev_valid, 1'b0);

        // randomized traffic with back-pressure phases
        for (int ph = 0; ph < 12; ph++) begin
            int rdy_pct;
            rdy_pct = (ph % 3 == 0) ? 5 : $urandom_range(30, 100);
            for (int c = 0; c < 250; c++) begin
                logic [3:0] flip;
                flip = '0;
                for (int b = 0; b < 4; b++) flip[b] = ($urandom_range(0, 9) == 0);
                btn_in   = btn_in ^ flip;
                ev_ready = ($urandom_range(1, 100) <= rdy_pct);
                ovf_clr  = ($urandom_range(0, 40) == 0);
                if (ph == 7 && c == 100) begin
                    rst = 1'b1;
                    #2;
                    rst = 1'b0;
                end
                step(1);
            end
        end
        ovf_clr = 1'b0;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/btn_event_ctrl.md
BTN_EVENT_CTRL -- requirements
Module: btn_event_ctrl

Interface
REQ-001 SHALL have parameter DBITS, default 16: debounce counter width; a level is accepted after 2^DBITS consecutive differing samples.
REQ-002 SHALL have parameter FDEPTH, default 4: event FIFO depth, power of two, minimum 2.
REQ-003 SHALL have port clk  in  1  sole clock, rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port btn_in  in  4  raw, asynchronous button levels from the wing pins; bit i is button i.
REQ-006 SHALL have port btn_state  out  4  debounced button levels.
REQ-007 SHALL have port ev_valid  out  1  FIFO non-empty.
REQ-008 SHALL have port ev_ready  in  1  consumer accepts the head event.
REQ-009 SHALL have port ev_data  out  8  head event {press, 5'b0, idx[1:0]}; press=1 on 0->1, 0 on 1->0.
REQ-010 SHALL have port ovf  out  1  sticky overflow flag.
REQ-011 SHALL have port ovf_clr  in  1  clears ovf.
REQ-012 SHALL have port irq  out  1  event-pending interrupt, registered.

Function
REQ-013 SHALL pass each btn_in bit through a 2-flop synchronizer before any other use.
REQ-014 SHALL, per button, increment a DBITS-bit counter while the synchronized level differs from btn_state[i], and clear it when they match.
REQ-015 SHALL update btn_state[i] and clear the counter on a cycle where the level differs and the counter equals 2^DBITS-1.
REQ-016 SHALL, on each btn_state[i] change, set pend[i] and record pol[i] as the new level in the same clock edge.
REQ-017 SHALL, if pend[i] is already set when btn_state[i] changes, set ovf and overwrite pol[i] with the new level.
REQ-018 SHALL, each cycle the FIFO can accept, push exactly one event for the lowest-index set pend bit and clear that bit.
REQ-019 SHALL treat the FIFO as able to accept when it is not full, or when it is full and a pop occurs in the same cycle.
REQ-020 SHALL, when the FIFO is full with no pop, hold all pend bits and lose no events beyond REQ-017.
REQ-021 SHALL provide show-ahead output: ev_data is valid whenever ev_valid is high.
REQ-022 SHALL pop only on the cycle where ev_valid and ev_ready are both high.
REQ-023 SHALL ignore ev_ready while the FIFO is empty.
REQ-024 SHALL wrap the FIFO pointers modulo FDEPTH and keep an occupancy count of 0..FDEPTH.
REQ-025 SHALL make the event visible on ev_valid one cycle after its pend bit is set, when the FIFO is empty.
REQ-026 SHALL have ovf_clr take priority over a simultaneous overflow set.

Reset
REQ-027 SHALL reset asynchronously on rst high, with all registers released on the first clk edge after rst falls.
REQ-028 SHALL reset to: btn_state=0, synchronizers=0, counters=0, pend=0, FIFO empty, ev_valid=0, ev_data=0, ovf=0, irq=0.
REQ-029 SHALL discard any queued and pending events when rst is asserted mid-operation.

Configuration
REQ-030 SHALL, with macro BTN_EVENT_IRQ_EN defined, drive irq as a register equal to the previous cycle's ev_valid OR ovf.
REQ-031 SHALL, without BTN_EVENT_IRQ_EN, tie irq to constant 0 and instantiate no irq logic.

Structure
REQ-032 SHALL place the event field positions (PRESS_BIT, IDX_LSB/MSB), the button count NBTN=4 and the event width EV_W=8 in shared package btn_event_pkg.
REQ-033 SHALL implement the per-button synchronizer, counter and btn_state bit in sub-module btn_debounce, instantiated 4 times; the arbiter and FIFO remain in the top module.

Verification
REQ-034 SHALL run all scenarios with DBITS=2 and FDEPTH=4.
REQ-035 SHALL test single press: btn_in[0] 0->1, held -> btn_state[0]=1 after 2 sync + 4 cycles; ev_valid next cycle with ev_data=8'h80; ev_ready=1 -> ev_valid=0.
REQ-036 SHALL test bounce rejection: btn_in[2] high 3 cycles then low -> btn_state unchanged, no event.
REQ-037 SHALL test simultaneous edges: btn_in=4'b1111 in one cycle -> events 80,81,82,83 on consecutive cycles; pop order matches.
REQ-038 SHALL test full FIFO: fill with 4 events, ev_ready=0, then btn3 press then release -> ovf=1, pend[3] held; on pop, 8'h03 is pushed; ovf_clr -> ovf=0.
REQ-039 SHALL test reset mid-operation: 2 events queued, rst pulse between clock edges -> ev_valid=0, ovf=0 and irq=0 immediately; irq (with BTN_EVENT_IRQ_EN) follows ev_valid by 1 cycle afterwards.
